// File: rtl/dtcm_arbt_pkg.sv
// dtcm_arbt_pkg: shared widths, requester-ID encodings and build defaults for
// the DTCM port arbiter.
//
// Project-wide widths (XLEN, DTCM_ADDR_WIDTH) normally arrive from the core
// defines; fall-back values are provided here so the slice stands alone.
// DTCM_ARBT_OUTS_DEPTH sets the default outstanding-command depth.
// Optional feature macro: DTCM_ARBT_RR_EN (round-robin arbitration).

`ifndef XLEN
`define XLEN 32
`endif

`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif

`ifndef DTCM_ARBT_OUTS_DEPTH
`define DTCM_ARBT_OUTS_DEPTH 2
`endif

package dtcm_arbt_pkg;

  localparam int XLEN           = `XLEN;
  localparam int ADDR_W         = `DTCM_ADDR_WIDTH;
  localparam int MASK_W         = `XLEN / 8;
  localparam int OUTS_DEPTH_DEF = `DTCM_ARBT_OUTS_DEPTH;

  // Requester IDs: EXU load/store path is master 0, bus/debug agent master 1.
  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  // The other requester, used when round-robin hands the turn over.
  function automatic req_id_e other_id(input req_id_e id);
    req_id_e res;
    case (id)
      REQ_M0:  res = REQ_M1;
      REQ_M1:  res = REQ_M0;
      default: res = REQ_M0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dtcm_arbt_id_fifo.sv
// arbt_id_fifo: 1-bit-wide synchronous FIFO holding the requester ID of each
// DTCM command still waiting for its response.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data       enqueue one ID (ignored when full)
//   pop                   dequeue head ID (ignored when empty)
//   pop_data              current head ID
//   full, empty           occupancy flags
// DEPTH must be a power of two, >= 1.

module arbt_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap at DEPTH-1; written explicitly so DEPTH=1 also works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] res;
    if (p == PTR_W'(DEPTH - 1)) begin
      res = PTR_W'(0);
    end else begin
      res = p + PTR_W'(1);
    end
    return res;
  endfunction

  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= '0;
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dtcm_arbt.sv
// dtcm_arbt: two-requester arbiter for the single DTCM command/response port.
//
// Master 0 is the EXU load/store path, master 1 the external/debug bus agent.
// A grant is held from the first cycle s_cmd_valid is raised until that
// command handshakes. The requester ID of every accepted command is queued
// so that in-order DTCM responses are steered back to the right master.
//
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   m{0,1}_cmd_valid/ready/addr/read/wdata/wmask   master command channels
//   m{0,1}_rsp_valid/ready/rdata                   master response channels
//   s_cmd_valid/ready/addr/read/wdata/wmask        command to DTCM
//   s_rsp_valid/ready/rdata                        response from DTCM
// Parameter OUTS_DEPTH: max outstanding commands (power of two, >= 1).
// Build macro DTCM_ARBT_RR_EN: round-robin between masters when both request;
// otherwise master 0 has fixed priority.

module dtcm_arbt
  import dtcm_arbt_pkg::*;
#(
  parameter int OUTS_DEPTH = OUTS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  input  logic [ADDR_W-1:0] m0_cmd_addr,
  input  logic              m0_cmd_read,
  input  logic [XLEN-1:0]   m0_cmd_wdata,
  input  logic [MASK_W-1:0] m0_cmd_wmask,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [XLEN-1:0]   m0_rsp_rdata,
  input  logic              m1_cmd_valid,
  output logic              m1_cmd_ready,
  input  logic [ADDR_W-1:0] m1_cmd_addr,
  input  logic              m1_cmd_read,
  input  logic [XLEN-1:0]   m1_cmd_wdata,
  input  logic [MASK_W-1:0] m1_cmd_wmask,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [XLEN-1:0]   m1_rsp_rdata,
  output logic              s_cmd_valid,
  input  logic              s_cmd_ready,
  output logic [ADDR_W-1:0] s_cmd_addr,
  output logic              s_cmd_read,
  output logic [XLEN-1:0]   s_cmd_wdata,
  output logic [MASK_W-1:0] s_cmd_wmask,
  input  logic              s_rsp_valid,
  output logic              s_rsp_ready,
  input  logic [XLEN-1:0]   s_rsp_rdata
);

  logic    hold_vld_r;
  req_id_e hold_id_r;
  req_id_e win_id_s;
  req_id_e sel_id_s;
  logic    sel_valid_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;
  logic    head_bit_s;
  req_id_e head_id_s;
  logic    cmd_hs_s;
  logic    rsp_hs_s;

`ifdef DTCM_ARBT_RR_EN
  req_id_e rr_last_r;

  // Remember who was granted last so the other master wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= REQ_M1;
    end else if (cmd_hs_s) begin
      rr_last_r <= sel_id_s;
    end
  end
`endif

  // Arbitration winner among the currently requesting masters.
  always_comb begin
    win_id_s = REQ_M0;
    if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef DTCM_ARBT_RR_EN
      win_id_s = other_id(rr_last_r);
`else
      win_id_s = REQ_M0;
`endif
    end else if (m1_cmd_valid) begin
      win_id_s = REQ_M1;
    end else begin
      win_id_s = REQ_M0;
    end
  end

  // A stalled command keeps its grant so the DTCM sees stable fields.
  assign sel_id_s = hold_vld_r ? hold_id_r : win_id_s;

  // Command mux towards the DTCM.
  always_comb begin
    sel_valid_s = m0_cmd_valid;
    s_cmd_addr  = m0_cmd_addr;
    s_cmd_read  = m0_cmd_read;
    s_cmd_wdata = m0_cmd_wdata;
    s_cmd_wmask = m0_cmd_wmask;
    case (sel_id_s)
      REQ_M1: begin
        sel_valid_s = m1_cmd_valid;
        s_cmd_addr  = m1_cmd_addr;
        s_cmd_read  = m1_cmd_read;
        s_cmd_wdata = m1_cmd_wdata;
        s_cmd_wmask = m1_cmd_wmask;
      end
      default: begin
        sel_valid_s = m0_cmd_valid;
        s_cmd_addr  = m0_cmd_addr;
        s_cmd_read  = m0_cmd_read;
        s_cmd_wdata = m0_cmd_wdata;
        s_cmd_wmask = m0_cmd_wmask;
      end
    endcase
  end

  // Readiness only looks at FIFO state, never at this cycle's response pop,
  // so there is no response-to-command combinational path.
  assign s_cmd_valid  = sel_valid_s & ~fifo_full_s;
  assign m0_cmd_ready = s_cmd_ready & ~fifo_full_s & (sel_id_s == REQ_M0);
  assign m1_cmd_ready = s_cmd_ready & ~fifo_full_s & (sel_id_s == REQ_M1);
  assign cmd_hs_s     = s_cmd_valid & s_cmd_ready;

  // Grant hold: set while the DTCM stalls an offered command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_r <= 1'b0;
      hold_id_r  <= REQ_M0;
    end else if (cmd_hs_s) begin
      hold_vld_r <= 1'b0;
    end else if (s_cmd_valid) begin
      hold_vld_r <= 1'b1;
      hold_id_r  <= sel_id_s;
    end
  end

  arbt_id_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_hs_s),
    .push_data (sel_id_s),
    .pop       (rsp_hs_s),
    .pop_data  (head_bit_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign head_id_s    = req_id_e'(head_bit_s);
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign rsp_hs_s     = s_rsp_valid & s_rsp_ready;

  // Response steering by the oldest outstanding requester ID; a response
  // with nothing outstanding is neither forwarded nor acknowledged.
  always_comb begin
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    s_rsp_ready  = 1'b0;
    if (!fifo_empty_s) begin
      case (head_id_s)
        REQ_M1: begin
          m1_rsp_valid = s_rsp_valid;
          s_rsp_ready  = m1_rsp_ready;
        end
        default: begin
          m0_rsp_valid = s_rsp_valid;
          s_rsp_ready  = m0_rsp_ready;
        end
      endcase
    end else begin
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      s_rsp_ready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dtcm_arbt.sv
// tb_dtcm_arbt: directed plus randomized checks of dtcm_arbt against a
// transaction-level model (queue of outstanding requester IDs, a held grant
// and the last granted master).

module tb_dtcm_arbt;
  import dtcm_arbt_pkg::*;

  localparam int DEPTH = 2;
`ifdef DTCM_ARBT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_cmd_valid, m1_cmd_valid;
  logic              m0_cmd_ready, m1_cmd_ready;
  logic [ADDR_W-1:0] m0_cmd_addr, m1_cmd_addr;
  logic              m0_cmd_read, m1_cmd_read;
  logic [XLEN-1:0]   m0_cmd_wdata, m1_cmd_wdata;
  logic [MASK_W-1:0] m0_cmd_wmask, m1_cmd_wmask;
  logic              m0_rsp_valid, m1_rsp_valid;
  logic              m0_rsp_ready, m1_rsp_ready;
  logic [XLEN-1:0]   m0_rsp_rdata, m1_rsp_rdata;
  logic              s_cmd_valid, s_cmd_ready;
  logic [ADDR_W-1:0] s_cmd_addr;
  logic              s_cmd_read;
  logic [XLEN-1:0]   s_cmd_wdata;
  logic [MASK_W-1:0] s_cmd_wmask;
  logic              s_rsp_valid, s_rsp_ready;
  logic [XLEN-1:0]   s_rsp_rdata;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit mq[$];
  bit lock_v, lock_id, last_id;
  bit exp_sel, exp_scv, exp_srr;

  always #5 clk = ~clk;

  dtcm_arbt #(.OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read),
    .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_rdata(s_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lock_v  = 1'b0;
    lock_id = 1'b0;
    last_id = 1'b1;
  endtask

  task automatic set_idle();
    m0_cmd_valid = 1'b0; m0_cmd_addr = '0; m0_cmd_read = 1'b0;
    m0_cmd_wdata = '0;   m0_cmd_wmask = '0;
    m1_cmd_valid = 1'b0; m1_cmd_addr = '0; m1_cmd_read = 1'b0;
    m1_cmd_wdata = '0;   m1_cmd_wmask = '0;
    s_cmd_ready  = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0;
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
  endtask

  // Let inputs settle, derive expectations from the rules, compare all outputs.
  task automatic evalc();
    bit full, empty, head, sel_v;
    #3;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    head  = empty ? 1'b0 : mq[0];
    if (lock_v) exp_sel = lock_id;
    else if (m0_cmd_valid && m1_cmd_valid) exp_sel = RR ? !last_id : 1'b0;
    else exp_sel = m1_cmd_valid && !m0_cmd_valid;
    sel_v   = exp_sel ? m1_cmd_valid : m0_cmd_valid;
    exp_scv = sel_v && !full;
    exp_srr = !empty && (head ? m1_rsp_ready : m0_rsp_ready);
    chk("s_cmd_valid", 64'(s_cmd_valid), 64'(exp_scv));
    chk("m0_cmd_ready", 64'(m0_cmd_ready), 64'(s_cmd_ready && !full && !exp_sel));
    chk("m1_cmd_ready", 64'(m1_cmd_ready), 64'(s_cmd_ready && !full && exp_sel));
    chk("s_cmd_addr", 64'(s_cmd_addr), 64'(exp_sel ? m1_cmd_addr : m0_cmd_addr));
    chk("s_cmd_read", 64'(s_cmd_read), 64'(exp_sel ? m1_cmd_read : m0_cmd_read));
    chk("s_cmd_wdata", 64'(s_cmd_wdata), 64'(exp_sel ? m1_cmd_wdata : m0_cmd_wdata));
    chk("s_cmd_wmask", 64'(s_cmd_wmask), 64'(exp_sel ? m1_cmd_wmask : m0_cmd_wmask));
    chk("m0_rsp_valid", 64'(m0_rsp_valid), 64'(s_rsp_valid && !empty && !head));
    chk("m1_rsp_valid", 64'(m1_rsp_valid), 64'(s_rsp_valid && !empty && head));
    chk("s_rsp_ready", 64'(s_rsp_ready), 64'(exp_srr));
    chk("m0_rsp_rdata", 64'(m0_rsp_rdata), 64'(s_rsp_rdata));
    chk("m1_rsp_rdata", 64'(m1_rsp_rdata), 64'(s_rsp_rdata));
  endtask

  // Clock edge: apply handshakes to the model, then move off the edge.
  task automatic tick();
    @(posedge clk);
    if (s_rsp_valid && exp_srr) void'(mq.pop_front());
    if (exp_scv && s_cmd_ready) begin
      mq.push_back(exp_sel);
      lock_v  = 1'b0;
      last_id = exp_sel;
    end else if (exp_scv) begin
      lock_v  = 1'b1;
      lock_id = exp_sel;
    end
    #1;
  endtask

  initial begin
    // Reset state with idle inputs
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #1;
    evalc();
    chk("rst_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
    chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    evalc();
    tick();

    // Simultaneous request right after reset goes to m0; m0 reads 0x10
    m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = ADDR_W'(16'h0010);
    m1_cmd_valid = 1'b1; m1_cmd_read = 1'b0; m1_cmd_addr = ADDR_W'(16'h0020);
    m1_cmd_wdata = 32'h1234_5678; m1_cmd_wmask = 4'hF;
    s_cmd_ready = 1'b1;
    evalc();
    chk("first_grant_m0", 64'(m0_cmd_ready), 64'd1);
    chk("first_grant_addr", 64'(s_cmd_addr), 64'h10);
    tick();

    // DTCM answers next cycle
    m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0; s_cmd_ready = 1'b0;
    s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF; m0_rsp_ready = 1'b1;
    evalc();
    chk("rsp_m0_valid", 64'(m0_rsp_valid), 64'd1);
    chk("rsp_m1_valid", 64'(m1_rsp_valid), 64'd0);
    chk("rsp_m0_data", 64'(m0_rsp_rdata), 64'hDEADBEEF);
    tick();

    // Both request every cycle; first cycle also hits a response with nothing outstanding
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1; s_cmd_ready = 1'b1;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rsp_rdata = XLEN'($urandom);
      evalc();
      if (i == 0) chk("empty_rsp_ready", 64'(s_rsp_ready), 64'd0);
      chk("alt_grant_m1", 64'(m1_cmd_ready), 64'(RR && (i % 2 == 0)));
      tick();
    end
    set_idle();
    s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    evalc(); tick();
    set_idle();

    // Grant hold: m1 stalled for 3 cycles while m0 joins
    m1_cmd_valid = 1'b1; m1_cmd_addr = ADDR_W'(16'h0ABC); m1_cmd_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        m0_cmd_valid = 1'b1; m0_cmd_addr = ADDR_W'(16'h0111);
      end
      evalc();
      chk("hold_addr", 64'(s_cmd_addr), 64'h0ABC);
      tick();
    end
    s_cmd_ready = 1'b1;
    evalc();
    chk("hold_m1_hs", 64'(m1_cmd_ready), 64'd1);
    tick();
    m1_cmd_valid = 1'b0;
    evalc();
    chk("after_hold_m0", 64'(m0_cmd_ready), 64'd1);
    tick();

    // FIFO full (m1, m0 outstanding): third command blocked
    evalc();
    chk("full_m0_ready", 64'(m0_cmd_ready), 64'd0);
    chk("full_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
    tick();
    s_rsp_valid = 1'b1; m1_rsp_ready = 1'b1;
    evalc();
    chk("full_pop_m1_valid", 64'(m1_rsp_valid), 64'd1);
    chk("full_pop_m0_ready", 64'(m0_cmd_ready), 64'd0);
    tick();
    s_rsp_valid = 1'b0; m1_rsp_ready = 1'b0;
    evalc();
    chk("third_accepted", 64'(m0_cmd_ready), 64'd1);
    tick();

    // Drain the two m0 entries, then queue one m1 command
    set_idle();
    s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1;
    evalc(); tick();
    evalc(); tick();
    set_idle();
    m1_cmd_valid = 1'b1; s_cmd_ready = 1'b1;
    evalc(); tick();
    set_idle();

    // m1 slow to accept its response
    s_rsp_valid = 1'b1; s_rsp_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      evalc();
      chk("stall_s_rsp_ready", 64'(s_rsp_ready), 64'd0);
      chk("stall_m1_valid", 64'(m1_rsp_valid), 64'd1);
      tick();
    end
    m1_rsp_ready = 1'b1;
    evalc();
    chk("stall_release", 64'(s_rsp_ready), 64'd1);
    chk("stall_data", 64'(m1_rsp_rdata), 64'hCAFEF00D);
    tick();
    set_idle();

    // Randomized traffic; a held master keeps its request stable
    for (int n = 0; n < 400; n++) begin
      if (!(lock_v && lock_id == 1'b0)) begin
        m0_cmd_valid = 1'($urandom_range(0, 1));
        m0_cmd_addr  = ADDR_W'($urandom);
        m0_cmd_read  = 1'($urandom_range(0, 1));
        m0_cmd_wdata = XLEN'($urandom);
        m0_cmd_wmask = MASK_W'($urandom);
      end
      if (!(lock_v && lock_id == 1'b1)) begin
        m1_cmd_valid = 1'($urandom_range(0, 1));
        m1_cmd_addr  = ADDR_W'($urandom);
        m1_cmd_read  = 1'($urandom_range(0, 1));
        m1_cmd_wdata = XLEN'($urandom);
        m1_cmd_wmask = MASK_W'($urandom);
      end
      s_cmd_ready  = ($urandom_range(0, 3) != 0);
      s_rsp_valid  = ($urandom_range(0, 2) != 0) && ((mq.size() > 0) || ($urandom_range(0, 7) == 0));
      s_rsp_rdata  = XLEN'($urandom);
      m0_rsp_ready = ($urandom_range(0, 3) != 0);
      m1_rsp_ready = ($urandom_range(0, 3) != 0);
      evalc();
      tick();
    end

    // Reset in mid-transaction: stalled grant plus outstanding entry discarded
    set_idle();
    m1_cmd_valid = 1'b1; s_cmd_ready = 1'b1;
    evalc(); tick();
    s_cmd_ready = 1'b0;
    evalc(); tick();
    rst_n = 1'b0;
    model_reset();
    set_idle();
    s_rsp_valid = 1'b1;
    evalc();
    chk("midrst_rsp_ready", 64'(s_rsp_ready), 64'd0);
    chk("midrst_m1_rsp", 64'(m1_rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle();
    m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1; s_cmd_ready = 1'b1;
    evalc();
    chk("postrst_grant_m0", 64'(m0_cmd_ready), 64'd1);
    tick();
    set_idle();
    evalc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
